// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// mux select codes and the per-state control word with its decode helpers.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic state_t next_state(input state_t s, input logic [6:0] op);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH: n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = S_EXECR;
          OP_I:         n = S_EXECI;
          OP_B:         n = S_BRANCH;
          OP_JAL:       n = S_JAL;
          OP_LUI:       n = S_LUI;
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR:  n = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: n = S_MEMWB;
      S_EXECR:   n = S_ALUWB;
      S_EXECI:   n = S_ALUWB;
      S_JAL:     n = S_ALUWB;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  // Control word that is valid for the whole time the FSM sits in state s.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    c.alu_op = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = SRCA_RD1;
        c.alu_src_b  = SRCB_RD2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      S_LUI: begin
        c.result_src = RES_IMM;
        c.reg_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    logic [2:0] imm;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_B:    imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      OP_LUI:  imm = IMM_U;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_decoder_mc.sv
// ALU operation decoder: turns the FSM's coarse alu_op request plus the
// instruction's funct fields into the ALU control code.
module alu_decoder_mc
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       opcode_5,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  // Only R-type (opcode_5 set) may request sub; addi ignores instr[30].
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (opcode_5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit_multicycle.sv
// Moore FSM sequencing the multicycle RISC-V datapath; the control word is
// registered together with the state so every output is glitch-free per state.
module control_unit_multicycle
  import riscv_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [2:0]         imm_src,
  output logic               reg_write,
  output logic [STATE_W-1:0] state
);

  state_t state_q;
  ctrl_t  ctrl_q;

  // The control register is loaded with the word of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= next_state(state_q, opcode);
      ctrl_q  <= state_ctrl(next_state(state_q, opcode));
    end
  end

  // Architectural writes are masked while reset is held so an abandoned
  // instruction, or the FETCH word loaded by reset, never commits anything.
  assign pc_write  = ~reset & (ctrl_q.pc_update | (ctrl_q.branch & (zero ^ funct3[0])));
  assign ir_write  = ~reset & ctrl_q.ir_write;
  assign mem_write = ~reset & ctrl_q.mem_write;
  assign reg_write = ~reset & ctrl_q.reg_write;

  assign adr_src    = ctrl_q.adr_src;
  assign result_src = ctrl_q.result_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign imm_src    = imm_decode(opcode);
  assign state      = STATE_W'(state_q);

  alu_decoder_mc u_alu_decoder (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (funct3),
    .opcode_5    (opcode[5]),
    .funct7_5    (funct7_5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_control_unit_multicycle.sv
// Scoreboard bench for control_unit_multicycle: per-cycle expected control
// words are queued per instruction and compared at each falling edge.
module tb_control_unit_multicycle;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic [3:0] state;
  logic [31:0] instr;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  control_unit_multicycle #(.STATE_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .reg_write   (reg_write),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pw;
    logic       mw;
    logic       rw;
    logic       iw;
    logic       adr;
    logic [1:0] rs;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [2:0] imm;
  } obs_t;

  typedef struct packed {
    logic        load;
    logic [31:0] ins;
    logic        z;
    obs_t        val;
    obs_t        mask;
  } sb_t;

  obs_t obs;
  assign obs = {state, pc_write, mem_write, reg_write, ir_write, adr_src,
                result_src, alu_src_a, alu_src_b, alu_control, imm_src};

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic drive(input logic [31:0] i);
    instr    = i;
    opcode   = i[6:0];
    funct3   = i[14:12];
    funct7_5 = i[30];
  endtask

  function automatic sb_t mk(input logic [3:0] st, input logic pw, mw, rw, iw, adr,
                             input logic [1:0] rs, sa, sbv, input logic [2:0] alu, imm);
    sb_t r;
    r.load = 1'b0;
    r.ins  = '0;
    r.z    = 1'b0;
    r.val  = {st, pw, mw, rw, iw, adr, rs, sa, sbv, alu, imm};
    r.mask = '1;
    return r;
  endfunction

  function automatic sb_t fetch_e(input logic [31:0] ins, input logic z, input logic [2:0] imm);
    sb_t r;
    r = mk(4'd0, H, L, L, H, L, 2'b10, 2'b00, 2'b10, 3'b000, imm);
    r.load = 1'b1;
    r.ins  = ins;
    r.z    = z;
    return r;
  endfunction

  function automatic sb_t decode_e(input logic [2:0] imm);
    return mk(4'd1, L, L, L, L, L, 2'b00, 2'b01, 2'b01, 3'b000, imm);
  endfunction

  function automatic sb_t aluwb_e(input logic [2:0] imm);
    return mk(4'd8, L, L, H, L, L, 2'b00, 2'b00, 2'b00, 3'b000, imm);
  endfunction

  task automatic push_lw(input logic [31:0] ins);
    sb_t wb;
    wb = mk(4'd4, L, L, H, L, H, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000);
    wb.mask.adr = 1'b0;
    sb.push_back(fetch_e(ins, L, 3'b000));
    sb.push_back(decode_e(3'b000));
    sb.push_back(mk(4'd2, L, L, L, L, L, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
    sb.push_back(mk(4'd3, L, L, L, L, H, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    sb.push_back(wb);
  endtask

  task automatic push_sw(input logic [31:0] ins);
    sb.push_back(fetch_e(ins, L, 3'b001));
    sb.push_back(decode_e(3'b001));
    sb.push_back(mk(4'd2, L, L, L, L, L, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001));
    sb.push_back(mk(4'd5, L, H, L, L, H, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001));
  endtask

  task automatic push_r(input logic [31:0] ins, input logic [2:0] alu);
    sb.push_back(fetch_e(ins, L, 3'b000));
    sb.push_back(decode_e(3'b000));
    sb.push_back(mk(4'd6, L, L, L, L, L, 2'b00, 2'b10, 2'b00, alu, 3'b000));
    sb.push_back(aluwb_e(3'b000));
  endtask

  task automatic push_i(input logic [31:0] ins, input logic [2:0] alu);
    sb.push_back(fetch_e(ins, L, 3'b000));
    sb.push_back(decode_e(3'b000));
    sb.push_back(mk(4'd7, L, L, L, L, L, 2'b00, 2'b10, 2'b01, alu, 3'b000));
    sb.push_back(aluwb_e(3'b000));
  endtask

  task automatic push_branch(input logic [31:0] ins, input logic z, input logic taken);
    sb.push_back(fetch_e(ins, z, 3'b010));
    sb.push_back(decode_e(3'b010));
    sb.push_back(mk(4'd9, taken, L, L, L, L, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010));
  endtask

  task automatic push_lui(input logic [31:0] ins);
    sb.push_back(fetch_e(ins, L, 3'b100));
    sb.push_back(decode_e(3'b100));
    sb.push_back(mk(4'd11, L, L, H, L, L, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100));
  endtask

  task automatic push_jal(input logic [31:0] ins);
    sb.push_back(fetch_e(ins, L, 3'b011));
    sb.push_back(decode_e(3'b011));
    sb.push_back(mk(4'd10, H, L, L, L, L, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011));
    sb.push_back(aluwb_e(3'b011));
  endtask

  task automatic push_illegal(input logic [31:0] ins);
    sb.push_back(fetch_e(ins, L, 3'b000));
    sb.push_back(decode_e(3'b000));
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({state, pc_write, ir_write, mem_write, reg_write} !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL reset_hold: got state=%0d writes=%b, expected state=0 writes=0000",
               state, {pc_write, ir_write, mem_write, reg_write});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({state, pc_write, ir_write} !== 6'b0000_11) begin
      n_err++;
      $display("[TB] FAIL reset_release: got state=%0d pc_write=%b ir_write=%b, expected 0 1 1",
               state, pc_write, ir_write);
    end
  endtask

  task automatic test_load_store;
    sb_t e;
    int  step = 0;
    push_lw(32'h00402283);
    push_sw(32'h0050A223);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.load) begin drive(e.ins); zero = e.z; end
      #1;
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("[TB] FAIL load_store step %0d instr=%h: got state=%0d word=%h, expected state=%0d word=%h",
                 step, instr, obs.st, obs, e.val.st, e.val);
      end
      step++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch;
    sb_t  e;
    int   step = 0;
    logic bn, zz;
    for (int k = 0; k < 4; k++) begin
      bn = (k >= 2);
      zz = (k % 2 == 1);
      push_branch(bn ? 32'h00001463 : 32'h00000463, zz, bn ? ~zz : zz);
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.load) begin drive(e.ins); zero = e.z; end
      #1;
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("[TB] FAIL branch step %0d instr=%h zero=%b: got state=%0d pc_write=%b word=%h, expected state=%0d pc_write=%b word=%h",
                 step, instr, zero, obs.st, obs.pw, obs, e.val.st, e.val.pw, e.val);
      end
      step++;
      @(negedge clk);
    end
  endtask

  task automatic test_lui_jal;
    sb_t e;
    int  step = 0;
    push_lui(32'h123452B7);
    push_jal(32'h008000EF);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.load) begin drive(e.ins); zero = e.z; end
      #1;
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("[TB] FAIL lui_jal step %0d instr=%h: got state=%0d word=%h, expected state=%0d word=%h",
                 step, instr, obs.st, obs, e.val.st, e.val);
      end
      step++;
      @(negedge clk);
    end
  endtask

  task automatic test_alu_decode;
    sb_t        e;
    int         step = 0;
    logic [2:0] f3 [7];
    logic [2:0] ex [7];
    f3 = '{3'b010, 3'b100, 3'b110, 3'b111, 3'b001, 3'b011, 3'b101};
    ex = '{3'b101, 3'b100, 3'b011, 3'b010, 3'b000, 3'b000, 3'b000};
    push_r(32'h40208033, 3'b001);
    push_i(32'h40208013, 3'b000);
    push_r(32'h00208033, 3'b000);
    for (int k = 0; k < 7; k++) begin
      push_i({12'h005, 5'd1, f3[k], 5'd5, 7'b0010011}, ex[k]);
      push_r({7'b0000000, 5'd2, 5'd1, f3[k], 5'd5, 7'b0110011}, ex[k]);
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.load) begin drive(e.ins); zero = e.z; end
      #1;
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("[TB] FAIL alu_decode step %0d instr=%h: got state=%0d alu_control=%b word=%h, expected state=%0d alu_control=%b word=%h",
                 step, instr, obs.st, obs.alu, obs, e.val.st, e.val.alu, e.val);
      end
      step++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_instr;
    sb_t e;
    int  step = 0;
    sb.push_back(fetch_e(32'h40208033, L, 3'b000));
    sb.push_back(decode_e(3'b000));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.load) begin drive(e.ins); zero = e.z; end
      #1;
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("[TB] FAIL reset_mid step %0d: got state=%0d word=%h, expected state=%0d word=%h",
                 step, obs.st, obs, e.val.st, e.val);
      end
      step++;
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (state !== 4'd6) begin
      n_err++;
      $display("[TB] FAIL reset_mid_execr: got state=%0d, expected 6", state);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL reset_mid_gate: got writes=%b, expected 0000",
               {pc_write, ir_write, mem_write, reg_write});
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({state, pc_write, ir_write, mem_write, reg_write} !== 8'h00) begin
        n_err++;
        $display("[TB] FAIL reset_mid_hold cycle %0d: got state=%0d writes=%b, expected state=0 writes=0000",
                 c, state, {pc_write, ir_write, mem_write, reg_write});
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({state, ir_write, reg_write} !== 6'b0000_10) begin
      n_err++;
      $display("[TB] FAIL reset_mid_release: got state=%0d ir_write=%b reg_write=%b, expected 0 1 0",
               state, ir_write, reg_write);
    end
  endtask

  task automatic test_back_to_back;
    sb_t e;
    int  step = 0;
    push_lw(32'h00402283);
    push_illegal(32'h0000007F);
    push_sw(32'h0050A223);
    push_illegal(32'h0000007F);
    push_r(32'h40208033, 3'b001);
    push_lui(32'h123452B7);
    push_branch(32'h00001463, L, H);
    push_jal(32'h008000EF);
    push_illegal(32'h0000007F);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.load) begin drive(e.ins); zero = e.z; end
      #1;
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("[TB] FAIL back_to_back step %0d instr=%h: got state=%0d word=%h, expected state=%0d word=%h",
                 step, instr, obs.st, obs, e.val.st, e.val);
      end
      step++;
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if ({state, pc_write, ir_write} !== 6'b0000_11) begin
      n_err++;
      $display("[TB] FAIL back_to_back_end: got state=%0d pc_write=%b ir_write=%b, expected 0 1 1",
               state, pc_write, ir_write);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    zero  = 1'b0;
    drive(32'h00000013);
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset;
    test_load_store;
    test_branch;
    test_lui_jal;
    test_alu_decode;
    test_reset_mid_instr;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
